sipo_i2s_rx: RTL and testbench

//  Serial-in/parallel-out I2S receiver for the codec ADC path (ADCDAT/BCLK/ADCLRC).

---
 rtl/sipo_i2s_rx.sv | 188 ++++++++++++++++++
 tb/tb_sipo_i2s_rx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_i2s_rx.sv
// I2S receiver: synchronises the codec ADC lines and deserialises each stereo frame.
// The completed left/right pair is handed off over valid/ready with sticky overrun.
module sipo_i2s_rx #(
   parameter int DATA_W      = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic              bclk_i,
   input  logic              lrck_i,
   input  logic              sdata_i,
   output logic [DATA_W-1:0] left_o,
   output logic [DATA_W-1:0] right_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              overrun_o,
   output logic              err_o
);

   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_e;

   logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, sdat_sync;
   logic                   bclk_s, lrck_s, sdata_s;
   logic                   bclk_d, lrck_q;
   logic                   bit_tick, lr_chg;

   state_e                 state_q, state_d;
   logic                   ch_q, ch_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]      sr_q, sr_d;
   logic [DATA_W-1:0]      lsh_q, lsh_d;
   logic                   lvld_q, lvld_d;
   logic                   err_d;
   logic                   commit;
   logic [DATA_W-1:0]      word;

   assign bclk_s   = bclk_sync[SYNC_STAGES-1];
   assign lrck_s   = lrck_sync[SYNC_STAGES-1];
   assign sdata_s  = sdat_sync[SYNC_STAGES-1];
   assign bit_tick = bclk_s & ~bclk_d;
   assign lr_chg   = lrck_s ^ lrck_q;
   assign word     = {sr_q[DATA_W-2:0], sdata_s};

   // Input synchronisers plus BCLK edge and LRCK change tracking
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bclk_sync <= '0;
         lrck_sync <= '0;
         sdat_sync <= '0;
         bclk_d    <= 1'b0;
         lrck_q    <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk_i};
         lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck_i};
         sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], sdata_i};
         bclk_d    <= bclk_s;
         if (bit_tick) lrck_q <= lrck_s;
      end
   end

   // Framing FSM state, shifter, count and left shadow
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ch_q    <= 1'b0;
         cnt_q   <= '0;
         sr_q    <= '0;
         lsh_q   <= '0;
         lvld_q  <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         lsh_q   <= lsh_d;
         lvld_q  <= lvld_d;
         err_o   <= err_d;
      end
   end

   // Next-state: the word-done tick may also be the next slot's delay bit
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      lsh_d   = lsh_q;
      lvld_d  = lvld_q;
      err_d   = 1'b0;
      commit  = 1'b0;
      if (!en_i) begin
         state_d = IDLE;
         ch_d    = 1'b0;
         cnt_d   = '0;
         sr_d    = '0;
         lsh_d   = '0;
         lvld_d  = 1'b0;
      end else if (bit_tick) begin
         unique case (state_q)
            IDLE: begin
               if (lr_chg && !lrck_s) begin
                  state_d = SHIFT;
                  ch_d    = 1'b0;
                  cnt_d   = '0;
               end
            end
            SHIFT: begin
               if (cnt_q == LAST) begin
                  sr_d    = word;
                  cnt_d   = '0;
                  state_d = WAIT;
                  if (!ch_q) begin
                     lsh_d  = word;
                     lvld_d = 1'b1;
                  end else begin
                     commit = lvld_q;
                     lvld_d = 1'b0;
                  end
                  if (lr_chg) begin
                     if (lrck_s != ch_q) begin
                        state_d = SHIFT;
                        ch_d    = lrck_s;
                     end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        lvld_d  = 1'b0;
                     end
                  end
               end else if (lr_chg) begin
                  err_d  = 1'b1;
                  sr_d   = '0;
                  cnt_d  = '0;
                  lvld_d = 1'b0;
                  if (ch_q) begin
                     state_d = lrck_s ? IDLE : SHIFT;
                     ch_d    = 1'b0;
                  end else begin
                     ch_d = 1'b1;
                  end
               end else begin
                  sr_d  = word;
                  cnt_d = cnt_q + CW'(1);
               end
            end
            WAIT: begin
               if (lr_chg) begin
                  if (lrck_s != ch_q) begin
                     state_d = SHIFT;
                     ch_d    = lrck_s;
                     cnt_d   = '0;
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                     lvld_d  = 1'b0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output pair register with valid/ready hand-off and sticky overrun
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         left_o    <= '0;
         right_o   <= '0;
         valid_o   <= 1'b0;
         overrun_o <= 1'b0;
      end else if (!en_i) begin
         valid_o   <= 1'b0;
         overrun_o <= 1'b0;
      end else if (commit) begin
         left_o  <= lsh_q;
         right_o <= word;
         valid_o <= 1'b1;
         if (valid_o && !ready_i) overrun_o <= 1'b1;
      end else if (valid_o && ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sipo_i2s_rx.sv
// Bench for sipo_i2s_rx: drives I2S frames from a table and hand-written
// corner sequences; delivered pairs are checked against a scoreboard queue.
module tb_sipo_i2s_rx;

   localparam int DW = 24;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          en_i = 1'b1;
   logic          bclk_i = 1'b0;
   logic          lrck_i = 1'b1;
   logic          sdata_i = 1'b0;
   logic          ready_i = 1'b1;
   logic [DW-1:0] left_o, right_o;
   logic          valid_o, overrun_o, err_o;

   always #5 clk = ~clk;

   sipo_i2s_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .en_i      (en_i),
      .bclk_i    (bclk_i),
      .lrck_i    (lrck_i),
      .sdata_i   (sdata_i),
      .left_o    (left_o),
      .right_o   (right_o),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .overrun_o (overrun_o),
      .err_o     (err_o)
   );

   typedef struct packed {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
   } pair_t;

   typedef struct {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
      int            slen;
   } vec_t;

   pair_t q[$];
   pair_t e;
   vec_t  vecs[7];
   int    checks = 0;
   int    fails = 0;
   int    err_cyc = 0;
   int    vcyc = 0;
   int    hs = 0;
   int    e0, v0, h0;
   logic  pend = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // one BCLK period; data lags LRCK by one bit (I2S delay bit)
   task automatic bit_out(input logic lr, input logic b);
      bclk_i  = 1'b0;
      lrck_i  = lr;
      sdata_i = pend;
      pend    = b;
      clk_n(8);
      bclk_i = 1'b1;
      clk_n(8);
   endtask

   function automatic logic wbit(input logic [DW-1:0] w, input int j);
      return (j < DW) ? w[DW-1-j] : 1'b0;
   endfunction

   task automatic slot(input logic lr, input logic [DW-1:0] w, input int nt);
      for (int k = 0; k < nt; k++) bit_out(lr, wbit(w, k));
   endtask

   task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                        input int slen, input bit push);
      if (push) q.push_back({l, r});
      slot(1'b0, l, slen);
      slot(1'b1, r, slen);
   endtask

   task automatic phase_reset();
      rst_ni  = 1'b0;
      bclk_i  = 1'b0;
      lrck_i  = 1'b1;
      sdata_i = 1'b0;
      pend    = 1'b0;
      clk_n(3);
      rst_ni = 1'b1;
      clk_n(2);
      slot(1'b1, '0, 2);
   endtask

   task automatic drain(input string nm);
      int t = 0;
      while (q.size() != 0 && t < 400) begin
         clk_n(1);
         t++;
      end
      chk(nm, 64'(q.size()), 64'd0);
      q.delete();
   endtask

   initial begin
      #20_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (rst_ni) begin
               if (err_o) err_cyc++;
               if (valid_o) vcyc++;
               if (valid_o && ready_i) begin
                  hs++;
                  if (q.size() == 0) begin
                     checks++;
                     fails++;
                     $display("FAIL unexpected_pair: got %h/%h expected none",
                              left_o, right_o);
                  end else begin
                     e = q.pop_front();
                     chk("pair_left", 64'(left_o), 64'(e.l));
                     chk("pair_right", 64'(right_o), 64'(e.r));
                  end
               end
            end
         end
      join_none

      vecs[0] = '{24'hA5C3F0, 24'h0F1E2D, 32};
      vecs[1] = '{24'hA5C3F0, 24'h0F1E2D, 32};
      vecs[2] = '{24'hA5C3F0, 24'h0F1E2D, 32};
      vecs[3] = '{24'h123ABC, 24'hFEDCBA, 24};
      vecs[4] = '{24'h800001, 24'h7FFFFE, 24};
      vecs[5] = '{24'hFFFFFF, 24'h000000, 24};
      vecs[6] = '{24'hA5C3F0, 24'h0F1E2D, 24};

      // reset state
      rst_ni = 1'b0;
      clk_n(3);
      chk("rst_left", 64'(left_o), 64'd0);
      chk("rst_right", 64'(right_o), 64'd0);
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_overrun", 64'(overrun_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);

      // table: 32-bit slots then back-to-back 24-bit slots, ready high
      phase_reset();
      e0 = err_cyc;
      v0 = vcyc;
      h0 = hs;
      for (int i = 0; i < 7; i++)
         frame(vecs[i].l, vecs[i].r, vecs[i].slen, 1'b1);
      slot(1'b0, '0, 1);
      drain("table_drain");
      chk("table_err", 64'(err_cyc - e0), 64'd0);
      chk("table_vcyc", 64'(vcyc - v0), 64'd7);
      chk("table_hs", 64'(hs - h0), 64'd7);
      chk("table_overrun", 64'(overrun_o), 64'd0);

      // enable mid right slot: only the next full frame is delivered
      en_i = 1'b0;
      phase_reset();
      h0 = hs;
      e0 = err_cyc;
      slot(1'b0, 24'h111111, 32);
      slot(1'b1, 24'h222222, 10);
      en_i = 1'b1;
      slot(1'b1, '0, 22);
      frame(24'hC0FFEE, 24'h0BEEF5, 32, 1'b1);
      slot(1'b0, '0, 1);
      drain("en_mid_drain");
      chk("en_mid_hs", 64'(hs - h0), 64'd1);
      chk("en_mid_err", 64'(err_cyc - e0), 64'd0);

      // overrun with ready low, then a one-cycle disable
      ready_i = 1'b0;
      phase_reset();
      frame(24'h13579B, 24'h2468AC, 32, 1'b0);
      chk("ovr_valid1", 64'(valid_o), 64'd1);
      chk("ovr_left1", 64'(left_o), 64'h13579B);
      chk("ovr_flag1", 64'(overrun_o), 64'd0);
      frame(24'h5A5A5A, 24'hC3C3C3, 32, 1'b0);
      chk("ovr_valid2", 64'(valid_o), 64'd1);
      chk("ovr_left2", 64'(left_o), 64'h5A5A5A);
      chk("ovr_right2", 64'(right_o), 64'hC3C3C3);
      chk("ovr_flag2", 64'(overrun_o), 64'd1);
      en_i = 1'b0;
      clk_n(1);
      en_i = 1'b1;
      chk("dis_valid", 64'(valid_o), 64'd0);
      chk("dis_overrun", 64'(overrun_o), 64'd0);
      chk("dis_hold", 64'(left_o), 64'h5A5A5A);
      ready_i = 1'b1;

      // short left slot: one err pulse, then a clean frame
      phase_reset();
      e0 = err_cyc;
      h0 = hs;
      slot(1'b0, 24'hABCDEF, 17);
      slot(1'b1, 24'h777777, 32);
      frame(24'h123456, 24'h654321, 32, 1'b1);
      slot(1'b0, '0, 1);
      drain("short_drain");
      chk("short_err", 64'(err_cyc - e0), 64'd1);
      chk("short_hs", 64'(hs - h0), 64'd1);

      // async reset in the right slot, then resync
      ready_i = 1'b0;
      phase_reset();
      frame(24'h9ABCDE, 24'h13579B, 32, 1'b0);
      chk("arst_pre_valid", 64'(valid_o), 64'd1);
      chk("arst_pre_left", 64'(left_o), 64'h9ABCDE);
      slot(1'b0, 24'h424242, 32);
      slot(1'b1, 24'h353535, 11);
      bclk_i  = 1'b0;
      lrck_i  = 1'b1;
      sdata_i = pend;
      clk_n(4);
      rst_ni = 1'b0;
      #1;
      chk("arst_left", 64'(left_o), 64'd0);
      chk("arst_right", 64'(right_o), 64'd0);
      chk("arst_valid", 64'(valid_o), 64'd0);
      chk("arst_overrun", 64'(overrun_o), 64'd0);
      chk("arst_err", 64'(err_o), 64'd0);
      clk_n(2);
      rst_ni  = 1'b1;
      ready_i = 1'b1;
      clk_n(2);
      bclk_i = 1'b1;
      clk_n(8);
      pend = 1'b0;
      h0 = hs;
      slot(1'b1, '0, 20);
      frame(24'h0A0B0C, 24'h0D0E0F, 32, 1'b1);
      slot(1'b0, '0, 1);
      drain("arst_drain");
      chk("arst_hs", 64'(hs - h0), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
